an_encoder_seq: RTL and testbench

- Sequential AN-code encoder: forms codeword = A × message with a serial shift-add multiplier, one message bit per cycle.
- Transmit-side counterpart of the Barrett-reduction AN decoder chain; its codeword output feeds that decoder's codeword input.
- Optional XOR error mask injects faults into the codeword, so decoder benches can exercise error detection from a single source.
- Valid/ready handshakes on both sides; one message in flight at a time.

---
 rtl/an_code_pkg.sv | 29 ++
 rtl/an_encoder_seq_if.sv | 29 ++
 rtl/an_shiftadd_mul.sv | 54 +++++
 rtl/an_encoder_seq.sv | 72 +++++++
 tb/tb_an_encoder_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/an_code_pkg.sv
// rtl/an_code_pkg.sv - shared AN-code constants, state encoding and clog2 helper
`timescale 1ns/1ps
package an_code_pkg;

  // Default code parameters; the decoder side imports the same values.
  localparam int AN_A_DEF     = 13;
  localparam int AN_MSG_W_DEF = 3;
  localparam int AN_CW_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } an_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/an_encoder_seq_if.sv
// rtl/an_encoder_seq_if.sv - message-in / codeword-out handshake bundle
`timescale 1ns/1ps
interface an_encoder_seq_if
  import an_code_pkg::*;
#(
  parameter int MSG_W = AN_MSG_W_DEF,
  parameter int CW_W  = AN_CW_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_msg;
  logic [CW_W-1:0]  in_err_mask;
  logic             out_valid;
  logic             out_ready;
  logic [CW_W-1:0]  out_codeword;
  logic             busy;

  // Source/sink side: feeds messages, consumes codewords.
  modport master (
    output in_valid, in_msg, in_err_mask, out_ready,
    input  in_ready, out_valid, out_codeword, busy
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_msg, in_err_mask, out_ready,
    output in_ready, out_valid, out_codeword, busy
  );
endinterface

// File: rtl/an_shiftadd_mul.sv
// rtl/an_shiftadd_mul.sv - serial shift-add multiplier, one multiplier bit per cycle
`timescale 1ns/1ps
module an_shiftadd_mul
  import an_code_pkg::*;
#(
  parameter int A     = AN_A_DEF,
  parameter int MSG_W = AN_MSG_W_DEF,
  parameter int CW_W  = AN_CW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MSG_W-1:0] msg,
  output logic             done,
  output logic [CW_W-1:0]  product
);
  localparam int CNT_W = clog2(MSG_W + 1);

  logic             running;
  logic [CW_W-1:0]  acc;
  logic [CW_W-1:0]  mcand;
  logic [MSG_W-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [CW_W-1:0]  partial;

  // product is the accumulator after this cycle's add, so the final value is
  // available on the same edge that done is seen.
  assign partial = mplier[0] ? mcand : '0;
  assign product = acc + partial;
  assign done    = running && (cnt == CNT_W'(MSG_W - 1));

  // Load operands on start, then add-and-shift for exactly MSG_W cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      acc     <= '0;
      mcand   <= CW_W'(A);
      mplier  <= msg;
      cnt     <= '0;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/an_encoder_seq.sv
// rtl/an_encoder_seq.sv - sequential AN-code encoder with optional fault mask
`timescale 1ns/1ps
module an_encoder_seq
  import an_code_pkg::*;
#(
  parameter int A     = AN_A_DEF,
  parameter int MSG_W = AN_MSG_W_DEF,
  parameter int CW_W  = AN_CW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  an_encoder_seq_if.slave  bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] MUL  = ST_MUL;
  localparam logic [1:0] DONE = ST_DONE;

  if ((A < 3) || ((A % 2) == 0)) begin : g_bad_a
    $error("an_encoder_seq: A must be odd and >= 3");
  end
  if (CW_W < MSG_W + clog2(A)) begin : g_bad_cw
    $error("an_encoder_seq: CW_W too narrow for A * (2^MSG_W - 1)");
  end

  logic [1:0]      state;
  logic [CW_W-1:0] mask;
  logic [CW_W-1:0] codeword;
  logic            start;
  logic            mul_done;
  logic [CW_W-1:0] product;

  assign start            = (state == IDLE) && bus.in_valid;
  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_codeword = codeword;

  an_shiftadd_mul #(
    .A     (A),
    .MSG_W (MSG_W),
    .CW_W  (CW_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .msg     (bus.in_msg),
    .done    (mul_done),
    .product (product)
  );

  // Handshake FSM; the mask is applied once to the finished product only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mask     <= '0;
      codeword <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mask  <= bus.in_err_mask;
          state <= MUL;
        end
        MUL: if (mul_done) begin
          codeword <= product ^ mask;
          state    <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_an_encoder_seq.sv
// tb/tb_an_encoder_seq.sv - directed scoreboard bench for an_encoder_seq
`timescale 1ns/1ps
module tb_an_encoder_seq;
  import an_code_pkg::*;

  localparam int A_C = 13;
  localparam int MW  = 3;
  localparam int CW  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  an_encoder_seq_if #(.MSG_W(MW), .CW_W(CW)) bus ();

  an_encoder_seq #(.A(A_C), .MSG_W(MW), .CW_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [CW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] model(input logic [MW-1:0] m, input logic [CW-1:0] k);
    int p;
    p = A_C * int'(m);
    return CW'(p) ^ k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [MW-1:0] m, input logic [CW-1:0] k, input bit track);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 0, 1);
      return;
    end
    bus.in_valid    = 1'b1;
    bus.in_msg      = m;
    bus.in_err_mask = k;
    tick();
    bus.in_valid = 1'b0;
    last_acc = cyc;
    if (track) exp_q.push_back(model(m, k));
  endtask

  task automatic recv(input int hold, output int lat);
    logic [CW-1:0] exp;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      check("recv_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_output", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    check("codeword", bus.out_codeword, exp);
    check("in_ready_done", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_codeword", bus.out_codeword, exp);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    tick();
    check("valid_drop", bus.out_valid, 0);
    check("ready_back", bus.in_ready, 1);
  endtask

  initial begin
    int lat;
    int prev;
    bus.in_valid    = 1'b0;
    bus.in_msg      = '0;
    bus.in_err_mask = '0;
    bus.out_ready   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_codeword", bus.out_codeword, 0);
    rst_n = 1'b1;
    tick();

    // msg 5, mask 0: latency 3, codeword 65
    bus.out_ready = 1'b1;
    send(3'd5, 7'd0, 1'b1);
    check("mul_in_ready", bus.in_ready, 0);
    check("mul_busy", bus.busy, 1);
    check("mul_out_valid", bus.out_valid, 0);
    recv(0, lat);
    check("latency_first", lat, 3);

    // Full sweep with back-to-back issue
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send(MW'(i), 7'd0, 1'b1);
      if (i > 0) check("issue_interval", last_acc - prev, 5);
      prev = last_acc;
      recv(0, lat);
      check("latency_sweep", lat, 3);
    end

    // Fault mask applied after multiplication
    send(3'd3, 7'b0000100, 1'b1);
    recv(0, lat);
    send(3'd3, 7'd0, 1'b1);
    recv(0, lat);
    send(3'd0, 7'h55, 1'b1);
    recv(0, lat);
    send(3'd7, 7'h7f, 1'b1);
    recv(0, lat);

    // Backpressure with a competing in_valid held high
    bus.out_ready = 1'b0;
    send(3'd7, 7'd0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_msg   = 3'd1;
    recv(6, lat);
    tick();
    check("bp_no_accept", bus.busy, 0);

    // Asynchronous reset in the middle of MUL
    send(3'd6, 7'd0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_codeword", bus.out_codeword, 0);
    check("arst_busy", bus.busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(3'd2, 7'd0, 1'b1);
    recv(0, lat);
    check("latency_after_reset", lat, 3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
